// File: rtl/vio_probe_bridge.sv
// rtl/vio_probe_bridge.sv - virtual-I/O probe bridge with register host port
//
// Samples twelve CPU debug signals into snapshot registers, tracks sticky
// per-probe activity, and drives an ALU B operand override into the datapath.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   probe_in0..11     debug probes (1,1,1,32,32,32,32,32,4,32,32,32 bits)
//   probe_out0        alternate ALU B operand
//   probe_out1        override select (1 = use probe_out0)
//   host_addr/wr/wdata/rd   word-addressed register access, single-cycle strobes
//   host_rdata/rvalid       registered read data, one-cycle valid pulse
module vio_probe_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        probe_in0,
    input  logic        probe_in1,
    input  logic        probe_in2,
    input  logic [31:0] probe_in3,
    input  logic [31:0] probe_in4,
    input  logic [31:0] probe_in5,
    input  logic [31:0] probe_in6,
    input  logic [31:0] probe_in7,
    input  logic [3:0]  probe_in8,
    input  logic [31:0] probe_in9,
    input  logic [31:0] probe_in10,
    input  logic [31:0] probe_in11,
    output logic [31:0] probe_out0,
    output logic        probe_out1,
    input  logic [4:0]  host_addr,
    input  logic        host_wr,
    input  logic [31:0] host_wdata,
    input  logic        host_rd,
    output logic [31:0] host_rdata,
    output logic        host_rvalid
);
    localparam logic [31:0] ID_VALUE  = 32'h5649_4F01;
    localparam logic [4:0]  ADDR_ACT  = 5'h0C;
    localparam logic [4:0]  ADDR_CTRL = 5'h0D;
    localparam logic [4:0]  ADDR_OUT0 = 5'h10;
    localparam logic [4:0]  ADDR_OUT1 = 5'h11;
    localparam logic [4:0]  ADDR_ID   = 5'h1F;

    logic [31:0] probe_ext [12];

    assign probe_ext[0]  = {31'd0, probe_in0};
    assign probe_ext[1]  = {31'd0, probe_in1};
    assign probe_ext[2]  = {31'd0, probe_in2};
    assign probe_ext[3]  = probe_in3;
    assign probe_ext[4]  = probe_in4;
    assign probe_ext[5]  = probe_in5;
    assign probe_ext[6]  = probe_in6;
    assign probe_ext[7]  = probe_in7;
    assign probe_ext[8]  = {28'd0, probe_in8};
    assign probe_ext[9]  = probe_in9;
    assign probe_ext[10] = probe_in10;
    assign probe_ext[11] = probe_in11;

    logic [31:0] snap_q [12];
    logic [31:0] snap_d [12];
    logic [31:0] prev_q [12];
    logic [31:0] prev_d [12];
    logic [11:0] act_q, act_d;
    logic        primed_q, primed_d;
    logic        auto_q, auto_d;
    logic [31:0] alt_q, alt_d;
    logic        sel_q, sel_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;

    logic        wr_act, wr_ctrl, wr_out0, wr_out1, capture;
    logic [11:0] diff;
    logic [11:0] clr_mask;
    logic [31:0] rd_mux;

    always_comb begin
        wr_act   = host_wr && (host_addr == ADDR_ACT);
        wr_ctrl  = host_wr && (host_addr == ADDR_CTRL);
        wr_out0  = host_wr && (host_addr == ADDR_OUT0);
        wr_out1  = host_wr && (host_addr == ADDR_OUT1);
        capture  = wr_ctrl && host_wdata[0];
        clr_mask = wr_act ? host_wdata[11:0] : 12'd0;

        diff = 12'd0;
        for (int i = 0; i < 12; i++) begin
            diff[i]   = (probe_ext[i] != prev_q[i]);
            prev_d[i] = probe_ext[i];
            snap_d[i] = (auto_q || capture) ? probe_ext[i] : snap_q[i];
        end

        // Clear first, then OR in new activity so a same-cycle set wins.
        act_d = act_q & ~clr_mask;
        if (primed_q) begin
            act_d = act_d | diff;
        end
        primed_d = 1'b1;

        auto_d = wr_ctrl ? host_wdata[1]    : auto_q;
        alt_d  = wr_out0 ? host_wdata       : alt_q;
        sel_d  = wr_out1 ? host_wdata[0]    : sel_q;

        // Read mux sees pre-write state; live probes stand in for snapshots
        // under AUTO since that is what the snapshot loads on this edge.
        rd_mux = 32'd0;
        case (host_addr)
            ADDR_ACT:  rd_mux = {20'd0, act_q};
            ADDR_CTRL: rd_mux = {30'd0, auto_q, 1'b0};
            ADDR_OUT0: rd_mux = alt_q;
            ADDR_OUT1: rd_mux = {31'd0, sel_q};
            ADDR_ID:   rd_mux = ID_VALUE;
            default: begin
                if (host_addr < 5'd12) begin
                    rd_mux = auto_q ? probe_ext[host_addr[3:0]] : snap_q[host_addr[3:0]];
                end
            end
        endcase

        rdata_d  = host_rd ? rd_mux : rdata_q;
        rvalid_d = host_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 12; i++) begin
                snap_q[i] <= 32'd0;
                prev_q[i] <= 32'd0;
            end
            act_q    <= 12'd0;
            primed_q <= 1'b0;
            auto_q   <= 1'b1;
            alt_q    <= 32'd0;
            sel_q    <= 1'b0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 12; i++) begin
                snap_q[i] <= snap_d[i];
                prev_q[i] <= prev_d[i];
            end
            act_q    <= act_d;
            primed_q <= primed_d;
            auto_q   <= auto_d;
            alt_q    <= alt_d;
            sel_q    <= sel_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign probe_out0  = alt_q;
    assign probe_out1  = sel_q;
    assign host_rdata  = rdata_q;
    assign host_rvalid = rvalid_q;
endmodule

// File: tb/tb_vio_probe_bridge.sv
// tb/tb_vio_probe_bridge.sv - self-checking bench for vio_probe_bridge
module tb_vio_probe_bridge;
    localparam logic [31:0] ID_VALUE = 32'h5649_4F01;

    logic        clk;
    logic        rst;
    logic [31:0] pv [12];
    logic        probe_in0, probe_in1, probe_in2;
    logic [31:0] probe_in3, probe_in4, probe_in5, probe_in6, probe_in7;
    logic [3:0]  probe_in8;
    logic [31:0] probe_in9, probe_in10, probe_in11;
    logic [31:0] probe_out0;
    logic        probe_out1;
    logic [4:0]  host_addr;
    logic        host_wr;
    logic [31:0] host_wdata;
    logic        host_rd;
    logic [31:0] host_rdata;
    logic        host_rvalid;

    assign probe_in0  = pv[0][0];
    assign probe_in1  = pv[1][0];
    assign probe_in2  = pv[2][0];
    assign probe_in3  = pv[3];
    assign probe_in4  = pv[4];
    assign probe_in5  = pv[5];
    assign probe_in6  = pv[6];
    assign probe_in7  = pv[7];
    assign probe_in8  = pv[8][3:0];
    assign probe_in9  = pv[9];
    assign probe_in10 = pv[10];
    assign probe_in11 = pv[11];

    vio_probe_bridge dut (
        .clk(clk), .rst(rst),
        .probe_in0(probe_in0), .probe_in1(probe_in1), .probe_in2(probe_in2),
        .probe_in3(probe_in3), .probe_in4(probe_in4), .probe_in5(probe_in5),
        .probe_in6(probe_in6), .probe_in7(probe_in7), .probe_in8(probe_in8),
        .probe_in9(probe_in9), .probe_in10(probe_in10), .probe_in11(probe_in11),
        .probe_out0(probe_out0), .probe_out1(probe_out1),
        .host_addr(host_addr), .host_wr(host_wr), .host_wdata(host_wdata),
        .host_rd(host_rd), .host_rdata(host_rdata), .host_rvalid(host_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: register file as the host sees it.
    logic [31:0] m_snap [12];
    logic [31:0] m_prev [12];
    logic [11:0] m_act;
    logic        m_primed;
    logic        m_auto;
    logic [31:0] m_out0;
    logic        m_out1;
    logic [31:0] m_rdata;
    logic        m_rvalid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_mask(input int i);
        if (i < 3) return 32'h1;
        if (i == 8) return 32'hF;
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 12; i++) begin
            m_snap[i] = 32'd0;
            m_prev[i] = 32'd0;
        end
        m_act = 12'd0; m_primed = 1'b0; m_auto = 1'b1;
        m_out0 = 32'd0; m_out1 = 1'b0; m_rdata = 32'd0; m_rvalid = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a < 5'd12) return m_auto ? pv[a[3:0]] : m_snap[a[3:0]];
        case (a)
            5'h0C: return {20'd0, m_act};
            5'h0D: return {30'd0, m_auto, 1'b0};
            5'h10: return m_out0;
            5'h11: return {31'd0, m_out1};
            5'h1F: return ID_VALUE;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(input logic rd, input logic wr, input logic [4:0] a, input logic [31:0] wd);
        logic [31:0] rv;
        logic [11:0] nact;
        rv = m_read(a);
        nact = m_act;
        if (wr && a == 5'h0C) nact = nact & ~wd[11:0];
        if (m_primed) begin
            for (int i = 0; i < 12; i++)
                if (pv[i] != m_prev[i]) nact[i] = 1'b1;
        end
        if (m_auto || (wr && a == 5'h0D && wd[0])) begin
            for (int i = 0; i < 12; i++) m_snap[i] = pv[i];
        end
        for (int i = 0; i < 12; i++) m_prev[i] = pv[i];
        m_primed = 1'b1;
        m_act = nact;
        if (wr) begin
            if (a == 5'h0D) m_auto = wd[1];
            if (a == 5'h10) m_out0 = wd;
            if (a == 5'h11) m_out1 = wd[0];
        end
        if (rd) m_rdata = rv;
        m_rvalid = rd;
    endtask

    // One host cycle: inputs applied at posedge+1, outputs compared at next posedge+1.
    task automatic cyc(input logic rd, input logic wr, input logic [4:0] a, input logic [31:0] wd);
        host_rd = rd; host_wr = wr; host_addr = a; host_wdata = wd;
        m_step(rd, wr, a, wd);
        @(posedge clk); #1;
        host_rd = 1'b0; host_wr = 1'b0;
        check("rvalid", {31'd0, host_rvalid}, {31'd0, m_rvalid});
        check("rdata", host_rdata, m_rdata);
        check("out0", probe_out0, m_out0);
        check("out1", {31'd0, probe_out1}, {31'd0, m_out1});
    endtask

    task automatic rd_expect(input string name, input logic [4:0] a, input logic [31:0] exp);
        cyc(1'b1, 1'b0, a, 32'd0);
        check(name, host_rdata, exp);
    endtask

    task automatic async_reset();
        #2; rst = 1'b1; #1;
        check("async_rst_out0", probe_out0, 32'd0);
        check("async_rst_out1", {31'd0, probe_out1}, 32'd0);
        check("async_rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        check("async_rst_rdata", host_rdata, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [10];

    initial begin
        logic [4:0] ra;
        logic       rrd, rwr;
        int         idx;
        int         r;
        logic [4:0] hot [6];

        vt[0] = '{5'h1F, 1'b0, 32'h0,         ID_VALUE};
        vt[1] = '{5'h10, 1'b1, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        vt[2] = '{5'h11, 1'b1, 32'hFFFF_FFFF, 32'h1};
        vt[3] = '{5'h11, 1'b1, 32'hFFFF_FFFE, 32'h0};
        vt[4] = '{5'h1F, 1'b1, 32'h0,         ID_VALUE};
        vt[5] = '{5'h15, 1'b1, 32'h1234,      32'h0};
        vt[6] = '{5'h0E, 1'b1, 32'hFFFF,      32'h0};
        vt[7] = '{5'h0D, 1'b0, 32'h0,         32'h2};
        vt[8] = '{5'h0D, 1'b1, 32'h3,         32'h2};
        vt[9] = '{5'h0C, 1'b1, 32'hFFF,       32'h0};

        for (int i = 0; i < 12; i++) pv[i] = 32'd0;
        rst = 1'b1; host_rd = 1'b0; host_wr = 1'b0; host_addr = 5'd0; host_wdata = 32'd0;
        model_reset();
        @(posedge clk); #1;
        check("reset_out0", probe_out0, 32'd0);
        check("reset_out1", {31'd0, probe_out1}, 32'd0);
        check("reset_rvalid", {31'd0, host_rvalid}, 32'd0);
        check("reset_rdata", host_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Register-map vectors
        for (int i = 0; i < 10; i++) begin
            if (vt[i].wr) cyc(1'b0, 1'b1, vt[i].addr, vt[i].wdata);
            cyc(1'b1, 1'b0, vt[i].addr, 32'd0);
            check($sformatf("vec%0d", i), host_rdata, vt[i].exp);
        end

        // Asynchronous reset with a read pending and the override engaged
        cyc(1'b0, 1'b1, 5'h11, 32'h1);
        cyc(1'b0, 1'b1, 5'h10, 32'hDEAD_BEEF);
        check("pre_rst_out0", probe_out0, 32'hDEAD_BEEF);
        cyc(1'b1, 1'b0, 5'h1F, 32'd0);
        check("pre_rst_rvalid", {31'd0, host_rvalid}, 32'h1);
        async_reset();
        rd_expect("id_after_rst", 5'h1F, ID_VALUE);
        check("id_rvalid", {31'd0, host_rvalid}, 32'h1);

        // Activity flags: quiet, single toggle, set-beats-clear, clean clear
        repeat (3) cyc(1'b0, 1'b0, 5'd0, 32'd0);
        rd_expect("act_quiet", 5'h0C, 32'h0);
        pv[1] = 32'h1;
        cyc(1'b0, 1'b0, 5'd0, 32'd0);
        rd_expect("act_toggle", 5'h0C, 32'h2);
        pv[1] = 32'h0;
        cyc(1'b0, 1'b1, 5'h0C, 32'h2);
        rd_expect("act_set_wins", 5'h0C, 32'h2);
        cyc(1'b0, 1'b1, 5'h0C, 32'h2);
        rd_expect("act_cleared", 5'h0C, 32'h0);

        // Override
        cyc(1'b0, 1'b1, 5'h10, 32'h5);
        check("ovr_out0_edge", probe_out0, 32'h5);
        cyc(1'b0, 1'b1, 5'h11, 32'h1);
        check("ovr_out1_edge", {31'd0, probe_out1}, 32'h1);
        rd_expect("ovr_rd_out0", 5'h10, 32'h5);
        rd_expect("ovr_rd_out1", 5'h11, 32'h1);

        // Snapshot freeze and manual capture
        cyc(1'b0, 1'b1, 5'h0D, 32'h0);
        pv[5] = 32'h3;
        cyc(1'b0, 1'b1, 5'h0D, 32'h1);
        pv[5] = 32'h4;
        cyc(1'b0, 1'b0, 5'd0, 32'd0);
        rd_expect("snap_frozen", 5'h05, 32'h3);
        rd_expect("ctrl_auto_off", 5'h0D, 32'h0);
        cyc(1'b0, 1'b1, 5'h0D, 32'h2);
        rd_expect("snap_auto", 5'h05, 32'h4);

        // Zero extension and unmapped read
        pv[8] = 32'hF;
        pv[0] = 32'h1;
        cyc(1'b0, 1'b0, 5'd0, 32'd0);
        rd_expect("ext_aluop", 5'h08, 32'hF);
        rd_expect("ext_branch", 5'h00, 32'h1);
        rd_expect("unmapped", 5'h15, 32'h0);

        // Same-address read/write collision
        cyc(1'b0, 1'b1, 5'h10, 32'h7);
        cyc(1'b1, 1'b1, 5'h10, 32'h9);
        check("collide_old", host_rdata, 32'h7);
        rd_expect("collide_new", 5'h10, 32'h9);

        // Randomized traffic against the model
        hot[0] = 5'h0C; hot[1] = 5'h0D; hot[2] = 5'h10;
        hot[3] = 5'h11; hot[4] = 5'h1F; hot[5] = 5'h05;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 11);
                pv[idx] = $urandom & m_mask(idx);
            end
            r = $urandom_range(0, 9);
            rrd = (r < 4);
            rwr = (r >= 3 && r < 7);
            if ($urandom_range(0, 1) == 0) ra = hot[$urandom_range(0, 5)];
            else ra = 5'($urandom_range(0, 31));
            cyc(rrd, rwr, ra, $urandom);
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
